// File: rtl/minicpu_ctrl_if.sv
// rtl/minicpu_ctrl_if.sv - MiniCPU controller instruction-memory and ALU bus
interface minicpu_ctrl_if #(
    parameter int PC_W = 6
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [7:0]      alu_op_a;
    logic [7:0]      alu_op_b;
    logic [2:0]      alu_op;
    logic [7:0]      alu_result;
    logic            alu_zero;

    modport master (
        output imem_addr, alu_op_a, alu_op_b, alu_op,
        input  imem_rdata, alu_result, alu_zero
    );

    modport slave (
        input  imem_addr, alu_op_a, alu_op_b, alu_op,
        output imem_rdata, alu_result, alu_zero
    );
endinterface

// File: rtl/minicpu_ctrl.sv
// rtl/minicpu_ctrl.sv - MiniCPU fetch/decode/execute/writeback controller
// Optional retired-instruction counter: define MINICPU_PERF_CNT_EN.
module minicpu_ctrl #(
    parameter int PC_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    minicpu_ctrl_if.master bus,
    output logic          halted,
    output logic          illegal,
    output logic          retire,
    input  logic [1:0]    dbg_sel,
    output logic [7:0]    dbg_data,
    output logic [15:0]   perf_retired
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nx;
    logic [7:0]      rf [4];
    logic [15:0]     ir;
    logic [7:0]      res_q;
    logic            z_q;
    logic            illegal_q;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       op_undef;

    assign op = ir[15:12];
    assign rd = ir[11:10];
    assign rs = ir[9:8];
    assign rt = ir[7:6];

    always_comb begin
        wr_en    = (op <= 4'd4) || (op == 4'd6);
        wr_data  = (op == 4'd6) ? ir[7:0] : res_q;
        op_undef = (op >= 4'd8) && (op <= 4'hE);
        pc_nx    = pc + PC_W'(1);
        if (op == 4'd5) begin
            pc_nx = z_q ? ir[PC_W-1:0] : pc + PC_W'(1);
        end else if (op == 4'hF) begin
            // HALT leaves the PC parked on itself so imem_addr holds
            pc_nx = pc;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = (op == 4'hF) ? S_HALT : S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        bus.alu_op_a = 8'd0;
        bus.alu_op_b = 8'd0;
        bus.alu_op   = 3'b111;
        if (state == S_EXEC) begin
            bus.alu_op_a = rf[rs];
            bus.alu_op_b = rf[rt];
            bus.alu_op   = op[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            rf[0]     <= 8'd0;
            rf[1]     <= 8'd0;
            rf[2]     <= 8'd0;
            rf[3]     <= 8'd0;
            ir        <= 16'd0;
            res_q     <= 8'd0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else if (run) begin
            state <= state_nx;
            case (state)
                S_DECODE: ir <= bus.imem_rdata;
                S_EXEC: begin
                    res_q <= bus.alu_result;
                    z_q   <= bus.alu_zero;
                end
                S_WB: begin
                    if (wr_en) begin
                        rf[rd] <= wr_data;
                    end
                    if (op_undef) begin
                        illegal_q <= 1'b1;
                    end
                    pc <= pc_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign halted        = (state == S_HALT);
    assign illegal       = illegal_q;
    // Masked by rst so a WB cycle that is being reset away never reports a retire
    assign retire        = run && !rst && (state == S_WB);
    assign dbg_data      = rf[dbg_sel];

`ifdef MINICPU_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 16'd0;
        end else if (retire && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_retired = perf_q;
`else
    assign perf_retired = 16'd0;
`endif
endmodule

// File: tb/tb_minicpu_ctrl.sv
// tb/tb_minicpu_ctrl.sv - scoreboard bench for minicpu_ctrl
module tb_minicpu_ctrl;
    logic        clk;
    logic        rst;
    logic        run;
    logic        halted;
    logic        illegal;
    logic        retire;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [15:0] perf_retired;

    logic        rst2;
    logic        run2;
    logic        halted2;
    logic        illegal2;
    logic        retire2;
    logic [1:0]  dbg_sel2;
    logic [7:0]  dbg_data2;
    logic [15:0] perf_retired2;

    logic [15:0] mem1 [64];
    logic [15:0] mem2 [4];

    minicpu_ctrl_if #(.PC_W(6)) bus1 ();
    minicpu_ctrl_if #(.PC_W(2)) bus2 ();

    minicpu_ctrl #(.PC_W(6)) dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus1),
        .halted(halted), .illegal(illegal), .retire(retire),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .perf_retired(perf_retired)
    );

    minicpu_ctrl #(.PC_W(2)) dut2 (
        .clk(clk), .rst(rst2), .run(run2), .bus(bus2),
        .halted(halted2), .illegal(illegal2), .retire(retire2),
        .dbg_sel(dbg_sel2), .dbg_data(dbg_data2), .perf_retired(perf_retired2)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a * b;
            3'd3:    r = a << 1;
            3'd4:    r = a >> 1;
            3'd5:    r = a - b;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        bus1.alu_result = alu_f(bus1.alu_op, bus1.alu_op_a, bus1.alu_op_b);
        bus1.alu_zero   = (bus1.alu_result == 8'd0);
        bus2.alu_result = alu_f(bus2.alu_op, bus2.alu_op_a, bus2.alu_op_b);
        bus2.alu_zero   = (bus2.alu_result == 8'd0);
    end

    always @(posedge clk) begin
        bus1.imem_rdata <= mem1[bus1.imem_addr];
        bus2.imem_rdata <= mem2[bus2.imem_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [5:0] pc;
        logic [5:0] npc;
        bit         chk;
        logic [1:0] rd;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_retire = 0;
    logic [1:0] main_sel = 2'd0;
    logic [1:0] mon_sel  = 2'd0;
    bit         mon_active = 1'b0;

    always_comb dbg_sel = mon_active ? mon_sel : main_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] pc, input logic [5:0] npc, input bit c,
                        input logic [1:0] rd, input logic [7:0] val);
        exp_t e;
        e.pc = pc; e.npc = npc; e.chk = c; e.rd = rd; e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: each retire pops one expected writeback and checks PC flow and the written register
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                n_retire++;
                if (exp_q.size() == 0) begin
                    chk("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_pc", 32'(bus1.imem_addr), 32'(e.pc));
                    mon_sel    = e.rd;
                    mon_active = 1'b1;
                    @(negedge clk);
                    chk("next_pc", 32'(bus1.imem_addr), 32'(e.npc));
                    if (e.chk) chk("reg_write", 32'(dbg_data), 32'(e.val));
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic fill_nops();
        for (int i = 0; i < 64; i++) mem1[i] = 16'h7000;
    endtask

    task automatic load_prog1();
        fill_nops();
        mem1[0] = 16'h6405;  // LDI r1,5
        mem1[1] = 16'h6803;  // LDI r2,3
        mem1[2] = 16'h0D80;  // ADD r3,r1,r2
        mem1[3] = 16'hF000;  // HALT
        exp_q.delete();
        push(6'd0, 6'd1, 1'b1, 2'd1, 8'd5);
        push(6'd1, 6'd2, 1'b1, 2'd2, 8'd3);
        push(6'd2, 6'd3, 1'b1, 2'd3, 8'd8);
        push(6'd3, 6'd3, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_reset(input bit check_state);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (check_state) begin
            chk("rst_imem_addr", 32'(bus1.imem_addr), 32'd0);
            chk("rst_alu_op", 32'(bus1.alu_op), 32'd7);
            chk("rst_alu_a", 32'(bus1.alu_op_a), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
            chk("rst_retire", 32'(retire), 32'd0);
            chk("rst_perf", 32'(perf_retired), 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic check_regs_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            main_sel = 2'(i);
            #1;
            chk(name, 32'(dbg_data), 32'd0);
        end
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
        chk("halt_reached", 32'(halted), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_retire2(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (retire2 === 1'b1) break;
        end
        chk("dut2_retire_seen", 32'(retire2), 32'd1);
    endtask

    initial begin
        int base;
        logic [1:0] addr_seq [5];
        rst = 1'b1; run = 1'b0;
        rst2 = 1'b1; run2 = 1'b0; dbg_sel2 = 2'd0;
        fill_nops();
        for (int i = 0; i < 4; i++) mem2[i] = 16'h7000;

        // Test 1: basic program, reset state and halt timing
        load_prog1();
        do_reset(1'b1);
        check_regs_zero("rst_reg");
        run  = 1'b1;
        base = n_retire;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t1_not_halted_c16", 32'(halted), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_halted_c17", 32'(halted), 32'd1);
        repeat (6) @(negedge clk);
        chk("t1_retire_count", 32'(n_retire - base), 32'd4);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_illegal", 32'(illegal), 32'd0);
`ifdef MINICPU_PERF_CNT_EN
        chk("t1_perf", 32'(perf_retired), 32'd4);
`else
        chk("t1_perf_tied", 32'(perf_retired), 32'd0);
`endif

        // Test 2: MUL wrap and SUB underflow
        fill_nops();
        mem1[0] = 16'h6414;  // LDI r1,20
        mem1[1] = 16'h680D;  // LDI r2,13
        mem1[2] = 16'h2D80;  // MUL r3,r1,r2
        mem1[3] = 16'h1240;  // SUB r0,r2,r1
        mem1[4] = 16'hF000;
        exp_q.delete();
        push(6'd0, 6'd1, 1'b1, 2'd1, 8'd20);
        push(6'd1, 6'd2, 1'b1, 2'd2, 8'd13);
        push(6'd2, 6'd3, 1'b1, 2'd3, 8'h04);
        push(6'd3, 6'd4, 1'b1, 2'd0, 8'hF9);
        push(6'd4, 6'd4, 1'b0, 2'd0, 8'd0);
        do_reset(1'b0);
        run  = 1'b1;
        base = n_retire;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t2_mul_alu_op", 32'(bus1.alu_op), 32'd2);
        chk("t2_mul_op_a", 32'(bus1.alu_op_a), 32'd20);
        chk("t2_mul_op_b", 32'(bus1.alu_op_b), 32'd13);
        wait_halt(100);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_retire_count", 32'(n_retire - base), 32'd5);
        main_sel = 2'd3;
        #1 chk("t2_final_r3", 32'(dbg_data), 32'h04);

        // Test 3: BEQ taken and not taken
        fill_nops();
        mem1[0]  = 16'h6401;  // LDI r1,1
        mem1[1]  = 16'h6802;  // LDI r2,2
        mem1[2]  = 16'h5150;  // BEQ r1,r1 -> 0x10
        mem1[16] = 16'h5185;  // BEQ r1,r2 -> 0x05 (not taken)
        mem1[17] = 16'hF000;
        exp_q.delete();
        push(6'd0,  6'd1,  1'b1, 2'd1, 8'd1);
        push(6'd1,  6'd2,  1'b1, 2'd2, 8'd2);
        push(6'd2,  6'h10, 1'b0, 2'd0, 8'd0);
        push(6'h10, 6'h11, 1'b0, 2'd0, 8'd0);
        push(6'h11, 6'h11, 1'b0, 2'd0, 8'd0);
        do_reset(1'b0);
        run = 1'b1;
        wait_halt(100);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 4: stall three cycles in ADD EXEC
        load_prog1();
        do_reset(1'b0);
        run  = 1'b1;
        base = n_retire;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t4_exec_op", 32'(bus1.alu_op), 32'd0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_stall_op", 32'(bus1.alu_op), 32'd0);
            chk("t4_stall_a", 32'(bus1.alu_op_a), 32'd5);
            chk("t4_stall_b", 32'(bus1.alu_op_b), 32'd3);
            chk("t4_stall_retire", 32'(retire), 32'd0);
        end
        run = 1'b1;
        wait_halt(100);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_retire_count", 32'(n_retire - base), 32'd4);

        // Test 6: reset during EXEC of the third instruction, then rerun
        load_prog1();
        do_reset(1'b0);
        run = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        load_prog1();
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_pc", 32'(bus1.imem_addr), 32'd0);
        chk("t6_rst_alu_op", 32'(bus1.alu_op), 32'd7);
        chk("t6_rst_retire", 32'(retire), 32'd0);
        check_regs_zero("t6_rst_reg");
        rst  = 1'b0;
        base = n_retire;
        wait_halt(100);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_retire_count", 32'(n_retire - base), 32'd4);
`ifdef MINICPU_PERF_CNT_EN
        chk("t6_perf", 32'(perf_retired), 32'd4);
`endif
        run = 1'b0;

        // Test 5: PC_W=2 wrap and illegal opcode on the second instance
        mem2[0] = 16'h6C2A;  // LDI r3,0x2A
        mem2[1] = 16'h7000;
        mem2[2] = 16'h9D80;  // undefined opcode 9
        mem2[3] = 16'h7000;
        addr_seq[0] = 2'd1; addr_seq[1] = 2'd2; addr_seq[2] = 2'd3;
        addr_seq[3] = 2'd0; addr_seq[4] = 2'd1;
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        run2 = 1'b1;
        chk("t5_start_addr", 32'(bus2.imem_addr), 32'd0);
        for (int k = 0; k < 5; k++) begin
            wait_retire2(20);
            @(negedge clk);
            chk("t5_addr_seq", 32'(bus2.imem_addr), 32'(addr_seq[k]));
            if (k == 1) chk("t5_illegal_before", 32'(illegal2), 32'd0);
            if (k == 2) chk("t5_illegal_after", 32'(illegal2), 32'd1);
        end
        run2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dbg_sel2 = 2'(i);
            #1 chk("t5_reg_unchanged", 32'(dbg_data2), 32'd0);
        end
        dbg_sel2 = 2'd3;
        #1 chk("t5_r3", 32'(dbg_data2), 32'h2A);
        chk("t5_not_halted", 32'(halted2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
